// File: rtl/uart_cmd_decoder_if.sv
// Bus bundle for the UART command decoder: received-byte strobe in,
// write strobe, target bank, error strobe and busy flag out.
interface uart_cmd_decoder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHN    = 4,
  parameter int CHN_WIDTH  = 3
);
  logic                          rx_valid_i;
  logic [7:0]                    rx_data_i;
  logic                          tr_valid_o;
  logic [CHN_WIDTH-1:0]          tr_chn_o;
  logic [DATA_WIDTH-1:0]         tr_data_o;
  logic [NUM_CHN*DATA_WIDTH-1:0] target_o;
  logic                          err_o;
  logic [1:0]                    err_code_o;
  logic                          busy_o;

  // Byte source / write consumer side
  modport master (
    output rx_valid_i, rx_data_i,
    input  tr_valid_o, tr_chn_o, tr_data_o, target_o, err_o, err_code_o, busy_o
  );

  // Decoder side
  modport slave (
    input  rx_valid_i, rx_data_i,
    output tr_valid_o, tr_chn_o, tr_data_o, target_o, err_o, err_code_o, busy_o
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Framed command decoder for the motor-control UART link.
// Frame: SYNC CMD CHN D[NB-1]..D[0] CHK, CHK = XOR of everything after SYNC.
// Valid frames write a per-channel target bank (single or broadcast) and
// forward each write as a one-cycle strobe; bad frames raise err_o.
module uart_cmd_decoder #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         NUM_CHN     = 4,
  parameter int         CHN_WIDTH   = 3,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_decoder_if.slave  bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [7:0] CMD_SET     = 8'h91;
  localparam logic [7:0] CMD_SET_ALL = 8'h92;
  localparam logic [7:0] CMD_STOP    = 8'h93;

  localparam logic [BW-1:0]        LAST_BYTE = BW'(NB - 1);
  localparam logic [TW-1:0]        TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CHN_WIDTH-1:0] LAST_IDX  = CHN_WIDTH'(NUM_CHN - 1);
  localparam logic [CHN_WIDTH:0]   NUM_CHN_W = (CHN_WIDTH + 1)'(NUM_CHN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_CHN,
    S_DATA,
    S_CHK,
    S_APPLY
  } state_t;

  state_t                             state_q,    state_d;
  logic [7:0]                         cmd_q,      cmd_d;
  logic [CHN_WIDTH-1:0]               chn_q,      chn_d;
  logic [DATA_WIDTH-1:0]              data_q,     data_d;
  logic [BW-1:0]                      bcnt_q,     bcnt_d;
  logic [7:0]                         xor_q,      xor_d;
  logic                               chk_seen_q, chk_seen_d;
  logic [TW-1:0]                      tmo_q,      tmo_d;
  logic [CHN_WIDTH-1:0]               wr_idx_q,   wr_idx_d;
  logic [NUM_CHN-1:0][DATA_WIDTH-1:0] bank_q,     bank_d;
  logic                               tr_valid_q, tr_valid_d;
  logic [CHN_WIDTH-1:0]               tr_chn_q,   tr_chn_d;
  logic [DATA_WIDTH-1:0]              tr_data_q,  tr_data_d;
  logic                               err_q,      err_d;
  logic [1:0]                         err_code_q, err_code_d;
  logic                               busy_q,     busy_d;

  logic                  cmd_known;
  logic                  chn_ok;
  logic                  last_wr;
  logic [DATA_WIDTH-1:0] wr_val;

  // Frame classification and write-value selection from the captured fields
  assign cmd_known = (cmd_q == CMD_SET) || (cmd_q == CMD_SET_ALL) || (cmd_q == CMD_STOP);
  assign chn_ok    = ({1'b0, chn_q} < NUM_CHN_W);
  assign last_wr   = (cmd_q == CMD_SET) || (wr_idx_q == LAST_IDX);
  assign wr_val    = (cmd_q == CMD_STOP) ? '0 : data_q;

  // Next-state logic: byte parsing, validation, timeout and write sequencing
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    chn_d      = chn_q;
    data_d     = data_q;
    bcnt_d     = bcnt_q;
    xor_d      = xor_q;
    chk_seen_d = chk_seen_q;
    tmo_d      = tmo_q;
    wr_idx_d   = wr_idx_q;
    bank_d     = bank_q;
    busy_d     = busy_q;
    // Strobes and their qualifiers are zero unless asserted this cycle
    tr_valid_d = 1'b0;
    tr_chn_d   = '0;
    tr_data_d  = '0;
    err_d      = 1'b0;
    err_code_d = 2'd0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.rx_valid_i && (bus.rx_data_i == SYNC_BYTE)) begin
          state_d    = S_CMD;
          busy_d     = 1'b1;
          xor_d      = 8'h00;
          tmo_d      = '0;
          bcnt_d     = '0;
          chk_seen_d = 1'b0;
        end
      end

      S_CMD, S_CHN, S_DATA, S_CHK: begin
        if ((state_q == S_CHK) && chk_seen_q) begin
          // Whole frame is in: checksum outranks command/channel checks
          chk_seen_d = 1'b0;
          if (xor_q != 8'h00) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            state_d    = S_IDLE;
            busy_d     = 1'b0;
          end else if (!cmd_known || ((cmd_q == CMD_SET) && !chn_ok)) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
            state_d    = S_IDLE;
            busy_d     = 1'b0;
          end else begin
            state_d  = S_APPLY;
            wr_idx_d = (cmd_q == CMD_SET) ? chn_q : '0;
          end
        end else if (bus.rx_valid_i) begin
          tmo_d = '0;
          xor_d = xor_q ^ bus.rx_data_i;
          case (state_q)
            S_CMD: begin
              cmd_d   = bus.rx_data_i;
              state_d = S_CHN;
            end
            S_CHN: begin
              chn_d   = bus.rx_data_i[CHN_WIDTH-1:0];
              bcnt_d  = '0;
              state_d = S_DATA;
            end
            S_DATA: begin
              // MSB first: shift earlier bytes up
              data_d = (data_q << 8) | DATA_WIDTH'(bus.rx_data_i);
              if (bcnt_q == LAST_BYTE) begin
                state_d = S_CHK;
              end else begin
                bcnt_d = bcnt_q + 1'b1;
              end
            end
            default: chk_seen_d = 1'b1;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          // Link went quiet mid-frame: drop the partial frame
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = S_IDLE;
          busy_d     = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_APPLY: begin
        // One channel per cycle; incoming bytes are ignored here
        tr_valid_d = 1'b1;
        tr_chn_d   = wr_idx_q;
        tr_data_d  = wr_val;
        for (int i = 0; i < NUM_CHN; i++) begin
          if (wr_idx_q == CHN_WIDTH'(i)) bank_d[i] = wr_val;
        end
        if (last_wr) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame or write burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      chn_q      <= '0;
      data_q     <= '0;
      bcnt_q     <= '0;
      xor_q      <= '0;
      chk_seen_q <= 1'b0;
      tmo_q      <= '0;
      wr_idx_q   <= '0;
      bank_q     <= '0;
      tr_valid_q <= 1'b0;
      tr_chn_q   <= '0;
      tr_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      chn_q      <= chn_d;
      data_q     <= data_d;
      bcnt_q     <= bcnt_d;
      xor_q      <= xor_d;
      chk_seen_q <= chk_seen_d;
      tmo_q      <= tmo_d;
      wr_idx_q   <= wr_idx_d;
      bank_q     <= bank_d;
      tr_valid_q <= tr_valid_d;
      tr_chn_q   <= tr_chn_d;
      tr_data_q  <= tr_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tr_valid_o = tr_valid_q;
  assign bus.tr_chn_o   = tr_chn_q;
  assign bus.tr_data_o  = tr_data_q;
  assign bus.target_o   = bank_q;
  assign bus.err_o      = err_q;
  assign bus.err_code_o = err_code_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: table of known frames, hand-built corner
// sequences (timeout, resets) and random frames against a frame-level model.
// Instance 0: 16-bit data, 4 channels. Instance 1: 24-bit data, 2 channels.
module tb_uart_cmd_decoder;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_decoder_if #(.DATA_WIDTH(16), .NUM_CHN(4), .CHN_WIDTH(3)) bus0 ();
  uart_cmd_decoder_if #(.DATA_WIDTH(24), .NUM_CHN(2), .CHN_WIDTH(3)) bus1 ();

  uart_cmd_decoder #(.DATA_WIDTH(16), .NUM_CHN(4), .CHN_WIDTH(3),
                     .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_cmd_decoder #(.DATA_WIDTH(24), .NUM_CHN(2), .CHN_WIDTH(3),
                     .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO))
    u1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int              inst;
    int              kind;   // 0 write, 1 error
    int              chn;    // channel, or error code
    longint unsigned data;
    int              cyc;
  } ev_t;

  typedef struct {
    int              inst;
    int              len;
    logic [63:0]     b;      // byte i at [63-8*i -: 8]
    int              err;
    int              nwr;
    int              chn;
    longint unsigned data;
  } vec_t;

  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              last_cyc = 0;
  ev_t             obs[$];
  ev_t             exp_q[$];
  logic [7:0]      stim[$];
  longint unsigned mbank[2][8];

  function automatic int nb(input int inst);
    return (inst == 0) ? 2 : 3;
  endfunction

  function automatic int nchn(input int inst);
    return (inst == 0) ? 4 : 2;
  endfunction

  function automatic longint unsigned tgt(input int inst, input int c);
    if (inst == 0) return 64'(bus0.target_o[c*16 +: 16]);
    return 64'(bus1.target_o[c*24 +: 24]);
  endfunction

  // which: 0 tr_valid, 1 tr_chn, 2 tr_data, 3 err, 4 busy, 5 target bank
  function automatic longint unsigned outv(input int inst, input int which);
    if (inst == 0) begin
      case (which)
        0: return 64'(bus0.tr_valid_o);
        1: return 64'(bus0.tr_chn_o);
        2: return 64'(bus0.tr_data_o);
        3: return 64'(bus0.err_o);
        4: return 64'(bus0.busy_o);
        default: return 64'(bus0.target_o);
      endcase
    end
    case (which)
      0: return 64'(bus1.tr_valid_o);
      1: return 64'(bus1.tr_chn_o);
      2: return 64'(bus1.tr_data_o);
      3: return 64'(bus1.err_o);
      4: return 64'(bus1.busy_o);
      default: return 64'(bus1.target_o);
    endcase
  endfunction

  task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Event capture per instance; qualifiers must be quiet without a strobe
  task automatic mon(input int inst, input logic v, input logic [2:0] c,
                     input logic [31:0] d, input logic e, input logic [1:0] ec);
    ev_t ev;
    ev.inst = inst;
    ev.cyc  = cyc;
    if (v) begin
      ev.kind = 0; ev.chn = int'(c); ev.data = 64'(d);
      obs.push_back(ev);
    end else begin
      chk($sformatf("idle_qualifiers_inst%0d", inst), 64'({c, d}), 64'd0);
    end
    if (e) begin
      ev.kind = 1; ev.chn = int'(ec); ev.data = 0;
      obs.push_back(ev);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.tr_valid_o, bus0.tr_chn_o, 32'(bus0.tr_data_o), bus0.err_o, bus0.err_code_o);
    mon(1, bus1.tr_valid_o, bus1.tr_chn_o, 32'(bus1.tr_data_o), bus1.err_o, bus1.err_code_o);
  end

  task automatic drive(input int inst, input logic v, input logic [7:0] d);
    if (inst == 0) begin
      bus0.rx_valid_i = v; bus0.rx_data_i = d;
    end else begin
      bus1.rx_valid_i = v; bus1.rx_data_i = d;
    end
  endtask

  // Send stim[lo..hi-1], each byte one cycle, random idle gaps up to maxgap
  task automatic send_stim(input int inst, input int maxgap, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(inst, 1'b1, stim[i]);
      last_cyc = cyc;
      @(negedge clk);
      drive(inst, 1'b0, 8'h00);
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    end
  endtask

  task automatic push_wr(input int inst, input int c, input longint unsigned v);
    ev_t ev;
    ev.inst = inst; ev.kind = 0; ev.chn = c; ev.data = v; ev.cyc = 0;
    exp_q.push_back(ev);
    mbank[inst][c] = v;
  endtask

  task automatic push_err(input int inst, input int code);
    ev_t ev;
    ev.inst = inst; ev.kind = 1; ev.chn = code; ev.data = 0; ev.cyc = 0;
    exp_q.push_back(ev);
  endtask

  // Frame-level model: scan stim for SYNC, slice out whole frames, classify
  task automatic model_stream(input int inst);
    int              i, n, c;
    longint unsigned v;
    logic [7:0]      x, cmd, chn;
    n = nb(inst);
    i = 0;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        i++;
      end else if (i + n + 4 > stim.size()) begin
        i = stim.size();
      end else begin
        cmd = stim[i+1];
        chn = stim[i+2];
        x   = cmd ^ chn;
        v   = 0;
        for (int j = 0; j < n; j++) begin
          v = v * 256 + 64'(stim[i+3+j]);
          x = x ^ stim[i+3+j];
        end
        x = x ^ stim[i+3+n];
        i = i + n + 4;
        c = int'(chn) % 8;
        if (x != 8'h00) push_err(inst, 1);
        else if (cmd < 8'h91 || cmd > 8'h93 || (cmd == 8'h91 && c >= nchn(inst))) push_err(inst, 2);
        else if (cmd == 8'h91) push_wr(inst, c, v);
        else for (int k = 0; k < nchn(inst); k++) push_wr(inst, k, (cmd == 8'h93) ? 64'd0 : v);
      end
    end
  endtask

  // Compare captured events (and optionally their timing) plus both banks
  task automatic compare(input string tag, input bit timing);
    int base;
    chk({tag, "_event_count"}, 64'(obs.size()), 64'(exp_q.size()));
    if (obs.size() == exp_q.size()) begin
      for (int k = 0; k < obs.size(); k++) begin
        chk($sformatf("%s_ev%0d_inst", tag, k), 64'(obs[k].inst), 64'(exp_q[k].inst));
        chk($sformatf("%s_ev%0d_kind", tag, k), 64'(obs[k].kind), 64'(exp_q[k].kind));
        chk($sformatf("%s_ev%0d_chn_or_code", tag, k), 64'(obs[k].chn), 64'(exp_q[k].chn));
        chk($sformatf("%s_ev%0d_data", tag, k), obs[k].data, exp_q[k].data);
        if (timing) begin
          base = last_cyc + ((exp_q[0].kind == 1) ? 2 : 3);
          chk($sformatf("%s_ev%0d_cycle", tag, k), 64'(obs[k].cyc), 64'(base + k));
        end
      end
    end
    for (int inst = 0; inst < 2; inst++)
      for (int c = 0; c < nchn(inst); c++)
        chk($sformatf("%s_bank_inst%0d_ch%0d", tag, inst, c), tgt(inst, c), mbank[inst][c]);
    chk($sformatf("%s_busy0_idle", tag), outv(0, 4), 64'd0);
    chk($sformatf("%s_busy1_idle", tag), outv(1, 4), 64'd0);
    obs.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    string nm[6];
    nm = '{"tr_valid", "tr_chn", "tr_data", "err", "busy", "target"};
    for (int inst = 0; inst < 2; inst++)
      for (int w = 0; w < 6; w++)
        chk($sformatf("%s_inst%0d_%s", tag, inst, nm[w]), outv(inst, w), 64'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 8; c++) mbank[i][c] = 0;
  endtask

  task automatic load_vec(input vec_t v);
    stim.delete();
    for (int i = 0; i < v.len; i++) stim.push_back(v.b[63-8*i -: 8]);
  endtask

  vec_t       tbl[14];
  int         inst, sel;
  logic [7:0] cmd, chn, x, b;

  initial begin
    tbl[0]  = '{0, 6, 64'hA5_91_02_01_F4_66_00_00, 0, 1, 2, 64'h01F4};
    tbl[1]  = '{0, 6, 64'hA5_92_00_12_34_B4_00_00, 0, 4, 0, 64'h1234};
    tbl[2]  = '{0, 6, 64'hA5_93_00_00_00_93_00_00, 0, 4, 0, 64'h0};
    tbl[3]  = '{0, 6, 64'hA5_91_01_00_10_00_00_00, 1, 0, 0, 64'h0};
    tbl[4]  = '{0, 6, 64'hA5_91_05_00_10_84_00_00, 2, 0, 0, 64'h0};
    tbl[5]  = '{0, 8, 64'h00_FF_A5_91_00_00_64_F5, 0, 1, 0, 64'h0064};
    tbl[6]  = '{0, 6, 64'hA5_90_00_00_00_90_00_00, 2, 0, 0, 64'h0};
    tbl[7]  = '{0, 6, 64'hA5_91_0B_00_07_9D_00_00, 0, 1, 3, 64'h0007};
    tbl[8]  = '{0, 6, 64'hA5_91_03_A5_5A_6D_00_00, 0, 1, 3, 64'hA55A};
    tbl[9]  = '{1, 7, 64'hA5_91_01_12_34_56_E0_00, 0, 1, 1, 64'h123456};
    tbl[10] = '{1, 7, 64'hA5_92_07_AB_CD_EF_1C_00, 0, 2, 0, 64'hABCDEF};
    tbl[11] = '{1, 7, 64'hA5_91_02_00_00_01_92_00, 2, 0, 0, 64'h0};
    tbl[12] = '{0, 6, 64'hA5_99_00_00_00_00_00_00, 1, 0, 0, 64'h0};
    tbl[13] = '{0, 6, 64'hA5_93_01_FF_FF_92_00_00, 0, 4, 0, 64'h0};

    clear_model();
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    obs.delete();

    // Table of known frames with hand-derived results
    for (int t = 0; t < 14; t++) begin
      load_vec(tbl[t]);
      if (tbl[t].err != 0) push_err(tbl[t].inst, tbl[t].err);
      else if (tbl[t].nwr == 1) push_wr(tbl[t].inst, tbl[t].chn, tbl[t].data);
      else for (int c = 0; c < tbl[t].nwr; c++) push_wr(tbl[t].inst, c, tbl[t].data);
      send_stim(tbl[t].inst, 0, 0, stim.size());
      repeat (10) @(negedge clk);
      #1;
      compare($sformatf("vec%0d", t), 1'b1);
    end

    // Timeout: SYNC + CMD then silence
    stim = '{8'hA5, 8'h91};
    send_stim(0, 0, 0, 2);
    #1;
    chk("tmo_busy_mid_frame", outv(0, 4), 64'd1);
    for (int t = 0; t < TMO + 10 && obs.size() == 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (obs.size() > 0) begin
      checks++;
      if (obs[0].cyc < last_cyc + TMO || obs[0].cyc > last_cyc + TMO + 2) begin
        errors++;
        $display("FAIL tmo_cycle got=%0d want=%0d..%0d", obs[0].cyc - last_cyc, TMO, TMO + 2);
      end
    end
    push_err(0, 3);
    repeat (3) @(negedge clk);
    #1;
    compare("tmo", 1'b0);
    load_vec(tbl[0]);
    model_stream(0);
    send_stim(0, 0, 0, stim.size());
    repeat (10) @(negedge clk);
    #1;
    compare("after_tmo", 1'b1);

    // Long gap just under the timeout must not abort the frame
    stim = '{8'hA5, 8'h91, 8'h01, 8'h77, 8'h88, 8'h6F};
    model_stream(0);
    send_stim(0, 0, 0, 3);
    repeat (TMO - 3) @(negedge clk);
    send_stim(0, 0, 3, 6);
    repeat (10) @(negedge clk);
    #1;
    compare("near_tmo", 1'b1);

    // Reset after payload MSB, both instances
    for (int r = 0; r < 2; r++) begin
      load_vec(tbl[(r == 0) ? 0 : 9]);
      send_stim(r, 0, 0, 4);
      rst = 1'b1;
      #1;
      check_all_zero($sformatf("rst_mid_frame%0d", r));
      clear_model();
      obs.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      load_vec(tbl[(r == 0) ? 1 : 9]);
      model_stream(r);
      send_stim(r, 0, 0, stim.size());
      repeat (10) @(negedge clk);
      #1;
      compare($sformatf("after_rst%0d", r), 1'b1);
    end

    // Reset in the middle of a broadcast burst: no writes after release
    load_vec(tbl[1]);
    send_stim(0, 0, 0, stim.size());
    for (int t = 0; t < 10 && obs.size() < 2; t++) begin
      @(negedge clk);
      #1;
    end
    chk("apply_writes_before_rst", 64'(obs.size()), 64'd2);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_apply");
    clear_model();
    obs.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    compare("rst_mid_apply_quiet", 1'b0);

    // Random frames with noise, random gaps and occasional bad fields
    for (int f = 0; f < 60; f++) begin
      inst = f % 2;
      stim.delete();
      repeat ($urandom_range(2, 0)) begin
        b = 8'($urandom_range(255, 0));
        if (b == 8'hA5) b = 8'h5A;
        stim.push_back(b);
      end
      stim.push_back(8'hA5);
      sel = int'($urandom_range(9, 0));
      cmd = (sel < 7) ? 8'h91 + 8'(sel % 3) : 8'($urandom_range(255, 0));
      chn = 8'($urandom_range(15, 0));
      stim.push_back(cmd);
      stim.push_back(chn);
      x = cmd ^ chn;
      for (int j = 0; j < nb(inst); j++) begin
        b = 8'($urandom);
        stim.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(4, 0) == 0) x = x ^ 8'(1 << $urandom_range(7, 0));
      stim.push_back(x);
      model_stream(inst);
      send_stim(inst, 3, 0, stim.size());
      repeat (12) @(negedge clk);
      #1;
      compare($sformatf("rand%0d", f), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
